// File: rtl/pc_pkg.sv
// Shared types and defaults for the PC fetch stage: FSM states, redirect
// sources and the reset/exception vector constants.
package pc_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      STALL  = 2'd1,
      BUBBLE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RD_NONE   = 2'd0,
      RD_BRANCH = 2'd1,
      RD_JUMP   = 2'd2,
      RD_EXC    = 2'd3
   } redirect_e;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

   function automatic logic addr_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit (master) and imem (slave).
// The request address is the fetch unit's pc_Out port.
interface pc_fetch_unit_if;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational redirect selection: exc > jump > branch, with misaligned
// jump/branch targets replaced by the exception vector.
module next_pc_sel
   import pc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_taken,
   input  logic [31:0] jump_target,
   input  logic        exc_req,
   output logic        redirect,
   output logic [31:0] target,
   output logic        misalign
);

   redirect_e   src_s;
   logic [31:0] raw_s;
   logic        align_chk_s;

   // Priority encode the redirect source
   always_comb begin
      src_s = RD_NONE;
      if (exc_req) begin
         src_s = RD_EXC;
      end else if (jump_taken) begin
         src_s = RD_JUMP;
      end else if (branch_taken) begin
         src_s = RD_BRANCH;
      end else begin
         src_s = RD_NONE;
      end
   end

   // Pick the raw target; only jump/branch targets are alignment-checked
   always_comb begin
      raw_s       = EXC_VECTOR;
      align_chk_s = 1'b0;
      case (src_s)
         RD_EXC: begin
            raw_s       = EXC_VECTOR;
            align_chk_s = 1'b0;
         end
         RD_JUMP: begin
            raw_s       = jump_target;
            align_chk_s = 1'b1;
         end
         RD_BRANCH: begin
            raw_s       = branch_target;
            align_chk_s = 1'b1;
         end
         default: begin
            raw_s       = EXC_VECTOR;
            align_chk_s = 1'b0;
         end
      endcase
      misalign = ALIGN_CHECK && align_chk_s && addr_misaligned(raw_s);
      target   = misalign ? EXC_VECTOR : raw_s;
      redirect = (src_s != RD_NONE);
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: next-PC selection, imem handshake and
// a registered instruction to decode with stall/flush.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
   parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   input  logic                    branch_taken,
   input  logic [31:0]             branch_target,
   input  logic                    jump_taken,
   input  logic [31:0]             jump_target,
   input  logic                    exc_req,
   input  logic [31:0]             pc_plus4_In,
   output logic [31:0]             pc_Out,
   pc_fetch_unit_if.master         imem,
   output logic [31:0]             instr_Out,
   output logic                    instr_valid,
   output logic                    misaligned
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;
   logic        req_s;
   logic        redirect_s;
   logic [31:0] target_s;
   logic        misalign_s;

   next_pc_sel #(
      .EXC_VECTOR  (EXC_VECTOR),
      .ALIGN_CHECK (ALIGN_CHECK)
   ) u_next_pc_sel (
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_taken    (jump_taken),
      .jump_target   (jump_target),
      .exc_req       (exc_req),
      .redirect      (redirect_s),
      .target        (target_s),
      .misalign      (misalign_s)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   // Next state; a redirect overrides everything, including a pending imem_ready
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mis_d   = 1'b0;
      if (redirect_s) begin
         state_d = BUBBLE;
         pc_d    = target_s;
         valid_d = 1'b0;
         mis_d   = misalign_s;
      end else begin
         case (state_q)
            FETCH: begin
               if (stall && valid_q) begin
                  state_d = STALL;
               end else if (req_s && imem.imem_ready) begin
                  instr_d = imem.imem_rdata;
                  valid_d = 1'b1;
                  pc_d    = pc_plus4_In;
               end else begin
                  valid_d = stall ? valid_q : 1'b0;
               end
            end
            STALL: begin
               // Decode takes the held word on the edge where stall drops
               if (!stall) begin
                  state_d = FETCH;
                  valid_d = 1'b0;
               end else begin
                  state_d = STALL;
               end
            end
            BUBBLE: begin
               state_d = FETCH;
            end
            default: begin
               state_d = FETCH;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // Fetch request, gated off while reset is asserted
   always_comb begin
      req_s = 1'b0;
      if (rst_n && (state_q == FETCH)) begin
         req_s = !(stall && valid_q);
      end else begin
         req_s = 1'b0;
      end
   end

   assign imem.imem_req = req_s;
   assign pc_Out        = pc_q;
   assign instr_Out     = instr_q;
   assign instr_valid   = valid_q;
   assign misaligned    = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a cycle-level reference model pushes the
// expected post-edge outputs, a negedge monitor pops and compares them.
module tb_pc_fetch_unit;

   localparam logic [31:0] EXC = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch_taken, jump_taken, exc_req;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_plus4_In, pc_Out, instr_Out;
   logic        instr_valid, misaligned;

   int n_cmp = 0;
   int n_err = 0;

   pc_fetch_unit_if bus ();

   pc_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_taken    (jump_taken),
      .jump_target   (jump_target),
      .exc_req       (exc_req),
      .pc_plus4_In   (pc_plus4_In),
      .pc_Out        (pc_Out),
      .imem          (bus),
      .instr_Out     (instr_Out),
      .instr_valid   (instr_valid),
      .misaligned    (misaligned)
   );

   always #5 clk = ~clk;

   // External incrementor and a memory whose word is derived from its address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction
   assign pc_plus4_In    = pc_Out + 32'd4;
   assign bus.imem_rdata = mem(pc_Out);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      logic        mis;
      logic        bubble;
      logic        stalled;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_pc, m_instr;
   logic        m_valid, m_bubble, m_stalled;

   // Reference model: what the fetch stage should look like after each edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 32'h0000_0000; m_instr = 32'h0000_0000;
         m_valid = 1'b0; m_bubble = 1'b0; m_stalled = 1'b0;
         q.delete();
      end else begin
         logic [31:0] raw;
         logic        red, chk_al, mis;
         red = 1'b1; chk_al = 1'b0; raw = EXC;
         if (exc_req) raw = EXC;
         else if (jump_taken) begin raw = jump_target; chk_al = 1'b1; end
         else if (branch_taken) begin raw = branch_target; chk_al = 1'b1; end
         else red = 1'b0;
         mis = chk_al && ((raw % 32'd4) != 32'd0);
         if (red) begin
            m_pc = mis ? EXC : raw;
            m_valid = 1'b0; m_bubble = 1'b1; m_stalled = 1'b0;
         end else if (m_bubble) begin
            m_bubble = 1'b0;
         end else if (m_stalled) begin
            if (!stall) begin m_stalled = 1'b0; m_valid = 1'b0; end
         end else if (stall && m_valid) begin
            m_stalled = 1'b1;
         end else if (bus.imem_ready) begin
            m_instr = mem(m_pc); m_valid = 1'b1; m_pc = m_pc + 32'd4;
         end else begin
            m_valid = 1'b0;
         end
         q.push_back('{m_pc, m_instr, m_valid, mis, m_bubble, m_stalled});
      end
   end

   // Monitor: compare DUT outputs against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && q.size() != 0) begin
         exp_t e;
         logic exp_req;
         e = q.pop_front();
         exp_req = !e.bubble && !e.stalled && !(stall && e.valid);
         chk("pc_Out", pc_Out, e.pc);
         chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
         chk("instr_Out", instr_Out, e.instr);
         chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
         chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
      end
   end

   task automatic cyc(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic e, input logic r);
      stall = s; branch_taken = b; branch_target = bt;
      jump_taken = j; jump_target = jt; exc_req = e; bus.imem_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"}, pc_Out, 32'h0000_0000);
      chk({tag, "_instr"}, instr_Out, 32'h0000_0000);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_mis"}, {31'd0, misaligned}, 32'd0);
      chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
   endtask

   initial begin
      logic [31:0] r1, r2;
      rst_n = 1'b0;
      stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0; exc_req = 1'b0;
      branch_target = 32'd0; jump_target = 32'd0; bus.imem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Zero-wait sequential fetch
      repeat (4) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      // Stall for 3 cycles with a valid word, then resume
      repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      // Jump beats branch
      cyc(1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      // Misaligned jump goes to the exception vector
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0102, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      // Exception while stalled with imem_ready high
      repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      // Address wrap through the incrementor
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      repeat (4) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r1 = $urandom();
         r2 = $urandom();
         if ($urandom_range(0, 5) != 0) r1 = r1 & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) != 0) r2 = r2 & 32'hFFFF_FFFC;
         cyc($urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0, r1,
             $urandom_range(0, 19) == 0, r2, $urandom_range(0, 29) == 0,
             $urandom_range(0, 9) < 7);
      end

      // Asynchronous reset in the middle of an unanswered request
      repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      bus.imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (4) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
